falafel_req_parser: RTL and testbench

FALAFEL_REQ_PARSER -- requirements
Module: falafel_req_parser

---
 rtl/falafel_pkg.sv | 35 +++
 rtl/falafel_fifo.sv | 59 +++++
 rtl/falafel_req_parser.sv | 178 +++++++++++++++++
 tb/tb_falafel_req_parser.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/falafel_pkg.sv
// Shared request-format definitions for the falafel request parser and its queues.
// Header fields sit in the low bits of a request beat: {addr, rw, id, opcode}.
package falafel_pkg;

  localparam int unsigned MSG_ID_SIZE   = 8;
  localparam int unsigned REG_ADDR_SIZE = 8;
  localparam int unsigned OPCODE_W      = 4;
  localparam int unsigned ENTRY_DATA_W  = 64;

  typedef enum logic [OPCODE_W-1:0] {
    REQ_ALLOC_MEM       = 4'h1,
    REQ_FREE_MEM        = 4'h2,
    REQ_ACCESS_REGISTER = 4'h3
  } opcode_e;

  typedef struct packed {
    logic [MSG_ID_SIZE-1:0] id;
    logic [OPCODE_W-1:0]    opcode;
  } base_header_t;

  typedef struct packed {
    logic [REG_ADDR_SIZE-1:0] addr;
    logic                     rw;
    base_header_t             base;
  } config_reg_header_t;

  // Queue entry layout; the parser ports carry the same {id, data} packing at any DATA_W.
  typedef struct packed {
    logic [MSG_ID_SIZE-1:0]  id;
    logic [ENTRY_DATA_W-1:0] data;
  } alloc_entry_t;

  localparam int unsigned CFG_HDR_W = $bits(config_reg_header_t);

endpackage

// File: rtl/falafel_fifo.sv
// Registered-output request queue with synchronous flush and occupancy count.
// No bypass in either direction: a push is visible one cycle later, full blocks pushes.
module falafel_fifo #(
  parameter int unsigned DATA_W      = 72,
  parameter int unsigned NUM_ENTRIES = 4,
  localparam int unsigned PTR_W      = $clog2(NUM_ENTRIES),
  localparam int unsigned CNT_W      = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  occ_o
);

  logic [DATA_W-1:0] mem_q [NUM_ENTRIES];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(NUM_ENTRIES));
  assign empty_o = (cnt_q == '0);
  assign occ_o   = cnt_q;
  assign data_o  = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/falafel_req_parser.sv
// Splits an incoming request stream into alloc/free queues and config strobes.
//   state         | meaning
//   ST_HDR        | expecting a header beat
//   ST_ALLOC_DATA | expecting the data beat of an alloc request
//   ST_FREE_DATA  | expecting the data beat of a free request
//   ST_CFG_DATA   | expecting the write data of a register access
module falafel_req_parser
  import falafel_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ERR_CNT_W  = 16,
  localparam int unsigned OCC_W     = $clog2(FIFO_DEPTH) + 1,
  localparam int unsigned ENTRY_W   = MSG_ID_SIZE + DATA_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 req_val_i,
  output logic                 req_rdy_o,
  input  logic [DATA_W-1:0]    req_data_i,
  output logic                 alloc_req_val_o,
  input  logic                 alloc_req_rdy_i,
  output logic [ENTRY_W-1:0]   alloc_req_data_o,
  output logic                 free_req_val_o,
  input  logic                 free_req_rdy_i,
  output logic [ENTRY_W-1:0]   free_req_data_o,
  output logic [OCC_W-1:0]     alloc_occ_o,
  output logic [OCC_W-1:0]     free_occ_o,
  output logic                 cfg_wr_o,
  output logic                 cfg_rd_o,
  output logic [DATA_W-1:0]    cfg_addr_o,
  output logic [DATA_W-1:0]    cfg_wdata_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {
    ST_HDR,
    ST_ALLOC_DATA,
    ST_FREE_DATA,
    ST_CFG_DATA
  } state_e;

  state_e                   state_q, state_d;
  logic [MSG_ID_SIZE-1:0]   id_q, id_d;
  logic [REG_ADDR_SIZE-1:0] addr_q, addr_d;
  logic [ERR_CNT_W-1:0]     err_cnt_q;
  config_reg_header_t       cfg_hdr;

  logic alloc_push, alloc_full, alloc_empty;
  logic free_push, free_full, free_empty;

  assign cfg_hdr = config_reg_header_t'(req_data_i[CFG_HDR_W-1:0]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_HDR;
      id_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    req_rdy_o   = 1'b0;
    alloc_push  = 1'b0;
    free_push   = 1'b0;
    cfg_wr_o    = 1'b0;
    cfg_rd_o    = 1'b0;
    cfg_addr_o  = '0;
    cfg_wdata_o = '0;
    err_o       = 1'b0;

    if (flush_i) begin
      state_d = ST_HDR;
    end else begin
      unique case (state_q)
        ST_HDR: begin
          req_rdy_o = 1'b1;
          if (req_val_i) begin
            id_d   = cfg_hdr.base.id;
            addr_d = cfg_hdr.addr;
            case (cfg_hdr.base.opcode)
              REQ_ALLOC_MEM: state_d = ST_ALLOC_DATA;
              REQ_FREE_MEM:  state_d = ST_FREE_DATA;
              REQ_ACCESS_REGISTER: begin
                if (cfg_hdr.rw) begin
                  state_d = ST_CFG_DATA;
                end else begin
                  // Reads carry no data beat: strobe straight from the header.
                  cfg_rd_o   = 1'b1;
                  cfg_addr_o = {{(DATA_W-REG_ADDR_SIZE){1'b0}}, cfg_hdr.addr};
                end
              end
              default: err_o = 1'b1;
            endcase
          end
        end
        ST_ALLOC_DATA: begin
          req_rdy_o = !alloc_full;
          if (req_val_i && !alloc_full) begin
            alloc_push = 1'b1;
            state_d    = ST_HDR;
          end
        end
        ST_FREE_DATA: begin
          req_rdy_o = !free_full;
          if (req_val_i && !free_full) begin
            free_push = 1'b1;
            state_d   = ST_HDR;
          end
        end
        ST_CFG_DATA: begin
          req_rdy_o = 1'b1;
          if (req_val_i) begin
            cfg_wr_o    = 1'b1;
            cfg_addr_o  = {{(DATA_W-REG_ADDR_SIZE){1'b0}}, addr_q};
            cfg_wdata_o = req_data_i;
            state_d     = ST_HDR;
          end
        end
        default: state_d = ST_HDR;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if (err_o && !(&err_cnt_q)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_cnt_o       = err_cnt_q;
  assign alloc_req_val_o = !alloc_empty;
  assign free_req_val_o  = !free_empty;

  falafel_fifo #(
    .DATA_W      (ENTRY_W),
    .NUM_ENTRIES (FIFO_DEPTH)
  ) u_alloc_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (alloc_push),
    .data_i  ({id_q, req_data_i}),
    .full_o  (alloc_full),
    .pop_i   (alloc_req_val_o && alloc_req_rdy_i),
    .data_o  (alloc_req_data_o),
    .empty_o (alloc_empty),
    .occ_o   (alloc_occ_o)
  );

  falafel_fifo #(
    .DATA_W      (ENTRY_W),
    .NUM_ENTRIES (FIFO_DEPTH)
  ) u_free_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (free_push),
    .data_i  ({id_q, req_data_i}),
    .full_o  (free_full),
    .pop_i   (free_req_val_o && free_req_rdy_i),
    .data_o  (free_req_data_o),
    .empty_o (free_empty),
    .occ_o   (free_occ_o)
  );

endmodule

// File: tb/tb_falafel_req_parser.sv
// Bench for falafel_req_parser: directed scenarios plus random traffic against a queue-level model.
module tb_falafel_req_parser;
  import falafel_pkg::*;

  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int EW    = MSG_ID_SIZE + DW;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic req_val = 1'b0;
  logic [DW-1:0] req_data = '0;
  logic a_rdy = 1'b0;
  logic f_rdy = 1'b0;

  logic          req_rdy, a_val, f_val, cfg_wr, cfg_rd, err;
  logic [EW-1:0] a_data, f_data;
  logic [OW-1:0] a_occ, f_occ;
  logic [DW-1:0] cfg_addr, cfg_wdata;
  logic [15:0]   err_cnt;

  logic          u2_rdy, u2_aval, u2_fval, u2_wr, u2_rd, u2_err;
  logic [EW-1:0] u2_adata, u2_fdata;
  logic [OW-1:0] u2_aocc, u2_focc;
  logic [DW-1:0] u2_addr, u2_wdata;
  logic [1:0]    err_cnt2;

  falafel_req_parser #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .ERR_CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_val_i(req_val), .req_rdy_o(req_rdy), .req_data_i(req_data),
    .alloc_req_val_o(a_val), .alloc_req_rdy_i(a_rdy), .alloc_req_data_o(a_data),
    .free_req_val_o(f_val), .free_req_rdy_i(f_rdy), .free_req_data_o(f_data),
    .alloc_occ_o(a_occ), .free_occ_o(f_occ),
    .cfg_wr_o(cfg_wr), .cfg_rd_o(cfg_rd), .cfg_addr_o(cfg_addr), .cfg_wdata_o(cfg_wdata),
    .err_o(err), .err_cnt_o(err_cnt)
  );

  falafel_req_parser #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .ERR_CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_val_i(req_val), .req_rdy_o(u2_rdy), .req_data_i(req_data),
    .alloc_req_val_o(u2_aval), .alloc_req_rdy_i(a_rdy), .alloc_req_data_o(u2_adata),
    .free_req_val_o(u2_fval), .free_req_rdy_i(f_rdy), .free_req_data_o(u2_fdata),
    .alloc_occ_o(u2_aocc), .free_occ_o(u2_focc),
    .cfg_wr_o(u2_wr), .cfg_rd_o(u2_rd), .cfg_addr_o(u2_addr), .cfg_wdata_o(u2_wdata),
    .err_o(u2_err), .err_cnt_o(err_cnt2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: what the next beat means, the two queue contents, and the error tally.
  typedef enum {K_HDR, K_ALLOC, K_FREE, K_CFG} kind_e;
  kind_e         m_kind = K_HDR;
  logic [EW-1:0] m_aq[$];
  logic [EW-1:0] m_fq[$];
  logic [7:0]    m_id = '0;
  logic [7:0]    m_addr = '0;
  int            m_err = 0;

  logic          last_acc, seen_rdy, seen_wr, seen_rd, seen_err;
  logic [DW-1:0] seen_addr, seen_wdata;

  function automatic logic [DW-1:0] mk_hdr(input logic [3:0] op, input logic [7:0] id,
                                          input logic rw, input logic [7:0] addr);
    logic [DW-1:0] h;
    h = '0;
    h[20:0] = {addr, rw, id, op};
    return h;
  endfunction

  task automatic model_reset();
    m_aq.delete();
    m_fq.delete();
    m_kind = K_HDR;
    m_id   = '0;
    m_addr = '0;
    m_err  = 0;
  endtask

  // Drive one beat, check combinational and registered outputs mid-cycle, then advance the model.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic fl);
    logic exp_rdy, acc, hdr, e_rd, e_err, e_wr, a_pop, f_pop;
    logic [3:0] op;
    req_val  = v;
    req_data = d;
    flush    = fl;
    @(negedge clk);
    if (fl)                    exp_rdy = 1'b0;
    else if (m_kind == K_ALLOC) exp_rdy = (m_aq.size() < DEPTH);
    else if (m_kind == K_FREE)  exp_rdy = (m_fq.size() < DEPTH);
    else                        exp_rdy = 1'b1;
    acc   = v && exp_rdy;
    op    = d[3:0];
    hdr   = acc && (m_kind == K_HDR);
    e_rd  = hdr && (op == 4'd3) && !d[12];
    e_err = hdr && !(op inside {4'd1, 4'd2, 4'd3});
    e_wr  = acc && (m_kind == K_CFG);

    check("req_rdy", req_rdy, exp_rdy);
    check("alloc_val", a_val, m_aq.size() > 0);
    check("alloc_occ", a_occ, m_aq.size());
    check("free_val", f_val, m_fq.size() > 0);
    check("free_occ", f_occ, m_fq.size());
    check("err", err, e_err);
    check("cfg_rd", cfg_rd, e_rd);
    check("cfg_wr", cfg_wr, e_wr);
    check("err_cnt", err_cnt, m_err > 65535 ? 65535 : m_err);
    check("err_cnt_sat", err_cnt2, m_err > 3 ? 3 : m_err);
    if (m_aq.size() > 0) check("alloc_data", a_data, m_aq[0]);
    if (m_fq.size() > 0) check("free_data", f_data, m_fq[0]);
    if (e_rd) check("cfg_rd_addr", cfg_addr, {56'b0, d[20:13]});
    if (e_wr) begin
      check("cfg_wr_addr", cfg_addr, {56'b0, m_addr});
      check("cfg_wdata", cfg_wdata, d);
    end

    last_acc   = acc;
    seen_rdy   = req_rdy;
    seen_wr    = cfg_wr;
    seen_rd    = cfg_rd;
    seen_err   = err;
    seen_addr  = cfg_addr;
    seen_wdata = cfg_wdata;
    a_pop = (m_aq.size() > 0) && a_rdy;
    f_pop = (m_fq.size() > 0) && f_rdy;

    @(posedge clk);
    if (fl) begin
      m_aq.delete();
      m_fq.delete();
      m_kind = K_HDR;
    end else begin
      if (a_pop) void'(m_aq.pop_front());
      if (f_pop) void'(m_fq.pop_front());
      if (acc) begin
        case (m_kind)
          K_HDR: begin
            m_id   = d[11:4];
            m_addr = d[20:13];
            if (op == 4'd1)      m_kind = K_ALLOC;
            else if (op == 4'd2) m_kind = K_FREE;
            else if (op == 4'd3) m_kind = d[12] ? K_CFG : K_HDR;
            else if (m_err < 65535) m_err++;
          end
          K_ALLOC: begin m_aq.push_back({m_id, d}); m_kind = K_HDR; end
          K_FREE:  begin m_fq.push_back({m_id, d}); m_kind = K_HDR; end
          default: m_kind = K_HDR;
        endcase
      end
    end
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, d, 1'b0);
      if (last_acc) break;
    end
    check("send_accept", last_acc, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, {$urandom, $urandom}, 1'b0);
  endtask

  task automatic apply_reset();
    req_val = 1'b0;
    flush   = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    check("rst_rdy", req_rdy, 1'b1);
    check("rst_alloc_val", a_val, 1'b0);
    check("rst_free_val", f_val, 1'b0);
    check("rst_occ", {a_occ, f_occ}, '0);
    check("rst_strobes", {cfg_wr, cfg_rd, err}, 3'b000);
    check("rst_err_cnt", err_cnt, 16'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic fl, v;

    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // Alloc id 5, data 0x100: visible one cycle after the push.
    a_rdy = 1'b0;
    f_rdy = 1'b0;
    send(mk_hdr(4'd1, 8'd5, 1'b0, 8'd0));
    send(64'h100);
    check("alloc_head", a_data, {8'd5, 64'h100});
    check("alloc_occ_1", a_occ, 3'd1);
    idle(1);

    // Fill the alloc queue, then stall the 5th data beat until space opens.
    for (int i = 1; i < 4; i++) begin
      send(mk_hdr(4'd1, 8'(i), 1'b0, 8'd0));
      send(64'(i * 16));
    end
    send(mk_hdr(4'd1, 8'd9, 1'b0, 8'd0));
    cycle(1'b1, 64'h555, 1'b0);
    check("full_stall", seen_rdy, 1'b0);
    a_rdy = 1'b1;
    cycle(1'b1, 64'h555, 1'b0);
    check("no_full_bypass", seen_rdy, 1'b0);
    a_rdy = 1'b0;
    cycle(1'b1, 64'h555, 1'b0);
    check("rdy_after_pop", seen_rdy, 1'b1);
    check("occ_after_refill", a_occ, 3'd4);
    a_rdy = 1'b1;
    idle(6);

    // Register write then register read.
    send(mk_hdr(4'd3, 8'd2, 1'b1, 8'h03));
    cycle(1'b1, 64'hDEAD, 1'b0);
    check("cfg_wr_pulse", seen_wr, 1'b1);
    check("cfg_wr_addr3", seen_addr, 64'h3);
    check("cfg_wr_data", seen_wdata, 64'hDEAD);
    cycle(1'b1, mk_hdr(4'd3, 8'd1, 1'b0, 8'h07), 1'b0);
    check("cfg_rd_pulse", seen_rd, 1'b1);
    check("cfg_rd_addr7", seen_addr, 64'h7);
    send(mk_hdr(4'd2, 8'd3, 1'b0, 8'd0));
    send(64'hF00D);
    idle(2);

    // Unknown opcodes, and the 2-bit counter saturating.
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, mk_hdr(4'(4 + 5 * i), 8'd0, 1'b0, 8'd0), 1'b0);
      check("err_pulse", seen_err, 1'b1);
    end
    idle(1);
    check("err_cnt_3", err_cnt, 16'd3);
    check("err_cnt2_3", err_cnt2, 2'd3);
    cycle(1'b1, mk_hdr(4'd0, 8'd0, 1'b0, 8'd0), 1'b0);
    cycle(1'b1, mk_hdr(4'hF, 8'd0, 1'b0, 8'd0), 1'b0);
    idle(1);
    check("err_cnt_5", err_cnt, 16'd5);
    check("err_cnt2_hold", err_cnt2, 2'd3);

    // Flush in the middle of a free request with two entries queued.
    f_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      send(mk_hdr(4'd2, 8'(i + 7), 1'b0, 8'd0));
      send(64'(i + 100));
    end
    send(mk_hdr(4'd2, 8'd9, 1'b0, 8'd0));
    cycle(1'b1, 64'h77, 1'b1);
    check("flush_rdy", seen_rdy, 1'b0);
    check("flush_occ", f_occ, 3'd0);
    check("flush_val", f_val, 1'b0);
    check("flush_err_cnt", err_cnt, 16'd5);
    f_rdy = 1'b1;
    send(mk_hdr(4'd1, 8'd4, 1'b0, 8'd0));
    send(64'h44);
    idle(2);

    // Reset between an alloc header and its data beat.
    send(mk_hdr(4'd1, 8'd6, 1'b0, 8'd0));
    apply_reset();
    cycle(1'b1, 64'h100, 1'b0);
    check("post_rst_hdr_err", seen_err, 1'b1);
    idle(1);
    check("post_rst_no_push", a_occ, 3'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      a_rdy = ($urandom % 3) != 0;
      f_rdy = ($urandom % 3) != 0;
      fl    = ($urandom % 50) == 0;
      v     = ($urandom % 4) != 0;
      d     = {$urandom, $urandom};
      if (m_kind == K_HDR && ($urandom % 5) != 0) d[3:0] = 4'($urandom_range(1, 3));
      cycle(v, d, fl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
